// File: rtl/key_debounce_if.sv
// Key conditioner bus: raw board levels and acknowledges in; clean levels,
// edge pulses and sticky event flags out.
interface key_debounce_if #(
  parameter int N_KEYS = 8
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] evt_ack;
  logic [N_KEYS-1:0] key_out;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] evt_pending;
  logic              any_evt;

  modport master (
    output key_raw, evt_ack,
    input  key_out, key_press, key_release, evt_pending, any_evt
  );

  modport slave (
    input  key_raw, evt_ack,
    output key_out, key_press, key_release, evt_pending, any_evt
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser and counting debouncer with press/release
// pulses and a sticky, acknowledgeable event flag for each key.
module key_debounce #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 18
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  key_debounce_if.slave keys
);

  typedef enum logic {STABLE, PENDING} state_t;

  localparam logic [N_KEYS-1:0] IDLE_LEVEL = {N_KEYS{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] meta_q, sync_q;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] evt_q, evt_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  state_t            state [N_KEYS];

  // State register: synchroniser, debounced level, counters, pulses, events.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      meta_q    <= IDLE_LEVEL;
      sync_q    <= IDLE_LEVEL;
      level_q   <= IDLE_LEVEL;
      press_q   <= '0;
      release_q <= '0;
      evt_q     <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      meta_q    <= keys.key_raw;
      sync_q    <= meta_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      evt_q     <= evt_d;
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // A running count is what distinguishes a pending change from a quiet key.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state[i] = (cnt_q[i] != '0) ? PENDING : STABLE;
    end
  end

  // Next-state logic.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      unique case (state[i])
        STABLE: begin
          if (sync_q[i] != level_q[i]) cnt_d[i] = cnt_q[i] + 1'b1;
        end
        PENDING: begin
          if (sync_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]     = '0;
            level_d[i]   = sync_q[i];
            press_d[i]   = (sync_q[i] != ACTIVE_LOW);
            release_d[i] = (sync_q[i] == ACTIVE_LOW);
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
    // A press in the same cycle as an acknowledge keeps the event set.
    evt_d = press_q | (evt_q & ~keys.evt_ack);
  end

  // Outputs.
  always_comb begin
    keys.key_out     = level_q;
    keys.key_press   = press_q;
    keys.key_release = release_q;
    keys.evt_pending = evt_q;
    keys.any_evt     = |evt_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a 4-cycle debounce window and
// active-low keys; expected values are hand-derived edge counts.
module tb_key_debounce;

  logic clk_in   = 1'b0;
  logic sys_rstn = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  int   presses;

  key_debounce_if #(.N_KEYS(8)) kif ();

  key_debounce #(
    .N_KEYS(8), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1), .CNT_W(3)
  ) dut (
    .clk_in  (clk_in),
    .sys_rstn(sys_rstn),
    .keys    (kif)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    kif.key_raw = 8'h00;
    kif.evt_ack = 8'h00;

    // 1. Asynchronous reset mid-cycle.
    #7;
    sys_rstn = 1'b0;
    #1;
    check("rst_key_out", kif.key_out, 8'hFF);
    check("rst_press", kif.key_press, 8'h00);
    check("rst_release", kif.key_release, 8'h00);
    check("rst_evt", kif.evt_pending, 8'h00);
    check("rst_any", {7'b0, kif.any_evt}, 8'h00);
    kif.key_raw = 8'hFF;
    tick(2);
    sys_rstn = 1'b1;
    tick(3);
    check("idle_key_out", kif.key_out, 8'hFF);

    // 2. Clean press of key 0.
    kif.key_raw = 8'hFE;
    tick(5);
    check("press_early_out", kif.key_out, 8'hFF);
    check("press_early_pulse", kif.key_press, 8'h00);
    tick(1);
    check("press_key_out", kif.key_out, 8'hFE);
    check("press_pulse", kif.key_press, 8'h01);
    check("press_no_release", kif.key_release, 8'h00);
    tick(1);
    check("press_pulse_end", kif.key_press, 8'h00);
    check("press_evt", kif.evt_pending, 8'h01);
    check("press_any", {7'b0, kif.any_evt}, 8'h01);

    // 3. Three-cycle glitch on key 3 is filtered.
    kif.key_raw = 8'hF6;
    tick(3);
    kif.key_raw = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      check("glitch_key_out", kif.key_out, 8'hFE);
      check("glitch_pulses", kif.key_press | kif.key_release, 8'h00);
      tick(1);
    end
    check("glitch_evt", kif.evt_pending, 8'h01);

    // 4. Release key 0 while acknowledging its event.
    kif.key_raw = 8'hFF;
    kif.evt_ack = 8'h01;
    tick(1);
    kif.evt_ack = 8'h00;
    check("ack_evt", kif.evt_pending, 8'h00);
    check("ack_any", {7'b0, kif.any_evt}, 8'h00);
    tick(4);
    check("release_early", kif.key_release, 8'h00);
    tick(1);
    check("release_pulse", kif.key_release, 8'h01);
    check("release_key_out", kif.key_out, 8'hFF);
    check("release_no_press", kif.key_press, 8'h00);
    tick(1);
    check("release_pulse_end", kif.key_release, 8'h00);
    check("release_evt", kif.evt_pending, 8'h00);

    // 5a. Press key 2 with its acknowledge held across the pulse cycle.
    kif.key_raw = 8'hFB;
    tick(5);
    kif.evt_ack = 8'h04;
    tick(1);
    check("simul_press2", kif.key_press, 8'h04);
    tick(1);
    kif.evt_ack = 8'h00;
    check("simul_set_wins", kif.evt_pending, 8'h04);
    tick(1);
    check("simul_evt_hold", kif.evt_pending, 8'h04);

    // 5b. Keys 5 and 6 pressed together.
    kif.key_raw = 8'h9B;
    tick(6);
    check("dual_press", kif.key_press, 8'h60);
    check("dual_key_out", kif.key_out, 8'h9B);
    tick(1);
    check("dual_evt", kif.evt_pending, 8'h64);

    // Return to idle and clear all events.
    kif.key_raw = 8'hFF;
    tick(8);
    kif.evt_ack = 8'hFF;
    tick(1);
    kif.evt_ack = 8'h00;
    check("idle2_key_out", kif.key_out, 8'hFF);
    check("idle2_evt", kif.evt_pending, 8'h00);

    // 6. Reset in the middle of a key 7 debounce.
    kif.key_raw = 8'h7F;
    tick(3);
    sys_rstn = 1'b0;
    #1;
    check("midrst_key_out", kif.key_out, 8'hFF);
    tick(1);
    sys_rstn = 1'b1;
    tick(5);
    check("midrst_early_out", kif.key_out, 8'hFF);
    check("midrst_early_pulse", kif.key_press, 8'h00);
    tick(1);
    check("midrst_key_out_fall", kif.key_out, 8'h7F);
    check("midrst_press", kif.key_press, 8'h80);
    presses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (kif.key_press[7]) presses++;
    end
    check("midrst_single_pulse", 8'(presses), 8'h00);
    check("midrst_evt", kif.evt_pending, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
